// File: rtl/esn_pkg.sv
// Shared constants and FSM state type for the ESN readout dump path.
package esn_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned N_OUT     = 8;
  localparam logic [15:0] TAG       = 16'hE5A0;
  localparam int unsigned FRAME_LEN = N_OUT + 3;
  localparam int unsigned IDX_W     = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    EST,
    WGT,
    CSUM
  } state_t;

endpackage

// File: rtl/esn_wout_dump.sv
// Snapshots est and W_out on request and streams them as a framed, XOR-checksummed
// word sequence over a valid/ready link; all stream outputs are registered.
module esn_wout_dump
  import esn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_N,
  input  logic                    ce,
  input  logic                    snap,
  input  logic [WORD_W-1:0]       est,
  input  logic [N_OUT*WORD_W-1:0] W_out,
  output logic [WORD_W-1:0]       m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy,
  output logic [7:0]              seq,
  output logic [7:0]              drop_cnt
);

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [WORD_W-1:0] csum_reg;
  logic [WORD_W-1:0] shadow_est_reg;
  logic [WORD_W-1:0] shadow_w_reg [N_OUT];
  logic [WORD_W-1:0] w_in [N_OUT];

  logic              beat;
  logic              req;
  logic              accept;
  logic              drop;
  logic              idx_last;
  logic [IDX_W-1:0]  idx_inc;
  logic [7:0]        seq_hdr;
  logic [WORD_W-1:0] hdr_word;
  logic [WORD_W-1:0] w_cur;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_unpack
      assign w_in[gi] = W_out[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign beat     = m_valid && m_ready;
  assign req      = snap && ce;
  // A back-to-back accept is only legal on the very edge that retires the checksum.
  assign accept   = req && ((state_reg == IDLE) || ((state_reg == CSUM) && beat));
  assign drop     = req && !accept;
  assign idx_last = (idx_reg == IDX_W'(N_OUT - 1));
  assign idx_inc  = idx_reg + 1'b1;
  assign w_cur    = shadow_w_reg[idx_reg];
  // seq advances on the same edge as a back-to-back accept, so the header uses the new value.
  assign seq_hdr  = (state_reg == CSUM) ? (seq + 8'd1) : seq;
  assign hdr_word = {TAG, seq_hdr, 8'(N_OUT)};

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      csum_reg       <= '0;
      shadow_est_reg <= '0;
      for (int i = 0; i < N_OUT; i++) shadow_w_reg[i] <= '0;
      m_data         <= '0;
      m_valid        <= 1'b0;
      m_last         <= 1'b0;
      busy           <= 1'b0;
      seq            <= 8'd0;
      drop_cnt       <= 8'd0;
    end else begin
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

      if (accept) begin
        shadow_est_reg <= est;
        for (int i = 0; i < N_OUT; i++) shadow_w_reg[i] <= w_in[i];
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= HDR;
            m_data    <= hdr_word;
            csum_reg  <= hdr_word;
            m_valid   <= 1'b1;
            m_last    <= 1'b0;
            busy      <= 1'b1;
          end
        end
        HDR: begin
          if (beat) begin
            state_reg <= EST;
            m_data    <= shadow_est_reg;
          end
        end
        EST: begin
          if (beat) begin
            state_reg <= WGT;
            idx_reg   <= '0;
            m_data    <= shadow_w_reg[0];
            csum_reg  <= csum_reg ^ shadow_est_reg;
          end
        end
        WGT: begin
          if (beat) begin
            csum_reg <= csum_reg ^ w_cur;
            if (idx_last) begin
              state_reg <= CSUM;
              m_data    <= csum_reg ^ w_cur;
              m_last    <= 1'b1;
            end else begin
              idx_reg <= idx_inc;
              m_data  <= shadow_w_reg[idx_inc];
            end
          end
        end
        CSUM: begin
          if (beat) begin
            seq    <= seq + 8'd1;
            m_last <= 1'b0;
            if (accept) begin
              state_reg <= HDR;
              m_data    <= hdr_word;
              csum_reg  <= hdr_word;
            end else begin
              state_reg <= IDLE;
              m_data    <= '0;
              m_valid   <= 1'b0;
              busy      <= 1'b0;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esn_wout_dump.sv
// Randomized directed bench for esn_wout_dump against a frame-level reference model.
module tb_esn_wout_dump;

  localparam int NW = 8;

  logic          clk = 1'b0;
  logic          rst_N;
  logic          ce;
  logic          snap;
  logic [31:0]   est;
  logic [NW*32-1:0] w_out;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic [7:0]    seq;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_est;
  logic [31:0] cap_w [NW];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  esn_wout_dump dut (
    .clk      (clk),
    .rst_N    (rst_N),
    .ce       (ce),
    .snap     (snap),
    .est      (est),
    .W_out    (w_out),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .seq      (seq),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Model of what an accept captures: remember the inputs as driven right now.
  task automatic capture();
    cap_est = est;
    for (int i = 0; i < NW; i++) cap_w[i] = w_out[i*32 +: 32];
  endtask

  task automatic randomize_inputs();
    est = $urandom;
    for (int i = 0; i < NW; i++) w_out[i*32 +: 32] = $urandom;
    capture();
  endtask

  // Expected frame: header, est, weights, XOR of everything before.
  task automatic build_frame(input logic [7:0] s);
    logic [31:0] x;
    exp_q.delete();
    exp_q.push_back({16'hE5A0, s, 8'd8});
    exp_q.push_back(cap_est);
    for (int i = 0; i < NW; i++) exp_q.push_back(cap_w[i]);
    x = 32'd0;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
  endtask

  // Drain one frame at negedges; pct = chance of m_ready per cycle.
  task automatic collect(input int pct, input bit b2b, input bit no_gap);
    int          got;
    int          cyc;
    int          n;
    bit          stalled;
    logic [31:0] held_data;
    logic        held_last;
    n = exp_q.size();
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    while (got < n && cyc < 2000) begin
      if (cyc == 0 && no_gap) chk("no_gap_valid", 32'(m_valid), 32'd1);
      if (got > 0) chk("valid_hold", 32'(m_valid), 32'd1);
      if (stalled) begin
        chk("stall_data", m_data, held_data);
        chk("stall_last", 32'(m_last), 32'(held_last));
      end
      m_ready = ($urandom_range(99) < pct);
      if (m_valid && m_ready) begin
        chk($sformatf("word%0d", got), m_data, exp_q[got]);
        chk($sformatf("last%0d", got), 32'(m_last), 32'(got == n - 1));
        $display("beat word=%0d data=%h last=%0b seq=%0d", got, m_data, m_last, seq);
        if (b2b && got == n - 1) begin
          randomize_inputs();
          snap = 1'b1;
          ce = 1'b1;
        end
        got++;
      end
      stalled = m_valid && !m_ready;
      held_data = m_data;
      held_last = m_last;
      @(negedge clk);
      cyc++;
    end
    snap = 1'b0;
    m_ready = 1'b0;
    if (got < n) chk("frame_timeout", 32'(got), 32'(n));
  endtask

  initial begin
    rst_N = 1'b0;
    ce = 1'b0;
    snap = 1'b0;
    m_ready = 1'b0;
    est = '0;
    w_out = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst_N = 1'b1;
    @(negedge clk);

    // Basic frame
    est = 32'h0000_1234;
    for (int i = 0; i < NW; i++) w_out[i*32 +: 32] = 32'h1000_0000 + i;
    capture();
    snap = 1'b1;
    ce = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("hdr_valid", 32'(m_valid), 32'd1);
    build_frame(8'd0);
    collect(100, 1'b0, 1'b0);
    chk("seq_after_basic", 32'(seq), 32'd1);
    chk("idle_valid", 32'(m_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Backpressure
    capture();
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    build_frame(8'd1);
    collect(30, 1'b0, 1'b0);

    // Snapshot atomicity
    capture();
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    w_out = '1;
    est = '1;
    build_frame(8'd2);
    collect(60, 1'b0, 1'b0);

    // Drops while busy and saturation
    randomize_inputs();
    snap = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    chk("drop_10", 32'(drop_cnt), 32'd10);
    repeat (290) @(negedge clk);
    snap = 1'b0;
    chk("drop_sat", 32'(drop_cnt), 32'd255);
    build_frame(8'd3);
    collect(100, 1'b0, 1'b0);
    ce = 1'b0;
    snap = 1'b1;
    repeat (5) @(negedge clk);
    snap = 1'b0;
    chk("ce_low_valid", 32'(m_valid), 32'd0);
    chk("ce_low_busy", 32'(busy), 32'd0);
    chk("ce_low_drop", 32'(drop_cnt), 32'd255);
    chk("ce_low_seq", 32'(seq), 32'd4);
    ce = 1'b1;

    // Back-to-back frames with seq wrap
    rst_N = 1'b0;
    @(negedge clk);
    rst_N = 1'b1;
    @(negedge clk);
    chk("b2b_seq_start", 32'(seq), 32'd0);
    randomize_inputs();
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    build_frame(8'd0);
    for (int f = 0; f < 257; f++) begin
      collect(100, f < 256, f > 0);
      if (f < 256) build_frame(8'((f + 1) % 256));
    end
    chk("b2b_seq_end", 32'(seq), 32'd1);
    chk("b2b_idle", 32'(m_valid), 32'd0);

    // Reset in the middle of a frame
    randomize_inputs();
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    build_frame(8'd1);
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    @(negedge clk);
    chk("mid_w3", m_data, exp_q[5]);
    chk("mid_drop", 32'(drop_cnt), 32'd1);
    rst_N = 1'b0;
    #1;
    chk("async_valid", 32'(m_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_seq", 32'(seq), 32'd0);
    chk("async_drop", 32'(drop_cnt), 32'd0);
    chk("async_last", 32'(m_last), 32'd0);
    @(negedge clk);
    m_ready = 1'b0;
    rst_N = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(m_valid), 32'd0);
    randomize_inputs();
    snap = 1'b1;
    @(negedge clk);
    snap = 1'b0;
    build_frame(8'd0);
    collect(50, 1'b0, 1'b0);
    chk("final_seq", 32'(seq), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/esn_wout_dump.md
# esn_wout_dump

Read-out side of the ESN core. On request, it snapshots the 32-bit estimate `est` and the packed readout weight vector `W_out` produced by `esn_top`. It then streams them to the host/debug link as a framed sequence of 32-bit words over a valid/ready handshake. It sits beside `esn_top` and consumes its outputs. Snapshots are atomic, so the core keeps running and training while a frame drains.

## Interface
- `N_OUT`, 8, number of readout weights in `W_out`
- `WORD_W`, 32, width of `est`, of each weight, and of every stream word
- `TAG`, 16'hE5A0, frame tag in header bits [31:16]
- `clk`  input  1  system clock, rising edge
- `rst_N`  input  1  reset; one clock, reset is asynchronous and active-low
- `ce`  input  1  capture enable; `snap` is ignored while low
- `snap`  input  1  snapshot request, sampled on the rising edge
- `est`  input  WORD_W  current ESN estimate
- `W_out`  input  N_OUT*WORD_W  weights; weight i = `W_out[i*WORD_W +: WORD_W]`
- `m_data`  output  WORD_W  stream word
- `m_valid`  output  1  `m_data` valid
- `m_ready`  input  1  sink accepts the word
- `m_last`  output  1  marks the final (checksum) word of a frame
- `busy`  output  1  frame in flight (state != IDLE)
- `seq`  output  8  sequence number of the next frame
- `drop_cnt`  output  8  saturating count of rejected snapshot requests

## Operation
- Frame: N_OUT+3 words, sent in this order:
  - header = {TAG, seq, N_OUT[7:0]}
  - `est`
  - W0..W(N_OUT-1)
  - checksum = XOR of all preceding words of the frame
- FSM states and transitions:
  - IDLE → HDR on accept
  - HDR → EST on beat
  - EST → WGT on beat
  - WGT holds an index 0..N_OUT-1; on beat with index = N_OUT-1 → CSUM
  - CSUM → IDLE on beat, or → HDR if a snapshot is accepted on that same cycle
- Beat: `m_valid && m_ready` on a rising edge.
- Accept: `snap && ce` when in IDLE, or when in CSUM during the beat cycle (back-to-back frames).
  - On accept, capture `est` and all of `W_out` into shadow registers.
  - Shadow registers change only on accept.
- `snap && ce` on any other cycle: the request is discarded and `drop_cnt` increments, saturating at 255.
- `snap` with `ce` low: ignored, not counted.
- `seq` increments (mod 256, 255→0) on the CSUM beat. The header carries the pre-increment value.
- Checksum: a running XOR register.
  - Loaded with the header value at accept.
  - XORed with each of `est` and W0..W(N_OUT-1) as they are beat.
  - Output as the CSUM word.
- Stream rules:
  - While `m_valid` is high and `m_ready` is low, `m_data` and `m_last` hold stable.
  - `m_valid` never drops without a beat.
  - `m_last` is high only in CSUM.
- Reset values: `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0, `seq`=0, `drop_cnt`=0, state IDLE, shadow and checksum registers 0.
- Reset mid-frame: all of the above take effect immediately (asynchronously). The partial frame is abandoned and no checksum word is emitted.

## Timing
- Accept at edge k → `m_valid`=1 with the header on `m_data` after edge k.
- With `m_ready` held high, one word per cycle:
  - the checksum word is presented after edge k+N_OUT+2;
  - `m_valid` falls after edge k+N_OUT+3, unless a back-to-back accept occurred.
- Back-to-back: accept on the CSUM beat edge → the new header is presented the next cycle, with no idle gap.
- `busy` is registered: high from the cycle after accept through the cycle of the final beat.
- `m_ready` may toggle arbitrarily; the only effect is stalling.
- No combinational path from `m_ready` to `m_valid` or `m_data`.
- `W_out`/`est` changes after the accept edge never reach the stream.

## Structure
- Shared package `esn_pkg`:
  - `WORD_W`, `N_OUT`, `TAG`
  - FSM state enum {IDLE, HDR, EST, WGT, CSUM}
  - frame length constant N_OUT+3
- No sub-module. The shadow register array, FSM, weight index counter and XOR accumulator are kept in one module.

## Test plan
- Basic frame: reset; `est`=32'h0000_1234; Wi=32'h1000_0000+i; `m_ready`=1; pulse `snap`.
  - 11 words: header 32'hE5A0_0008, 32'h0000_1234, 32'h1000_0000..32'h1000_0007, checksum = XOR of the first 10 words.
  - `m_last` only on word 11; `seq` reads 1 afterwards.
- Backpressure: same stimulus, `m_ready` toggled randomly (30% high).
  - Identical word sequence; `m_data` stable across every stalled cycle.
- Snapshot atomicity: change all Wi to 32'hFFFF_FFFF the cycle after accept.
  - Stream still carries the original values.
- Drop and saturation: pulse `snap` 300 times while `busy`.
  - `drop_cnt` = 255.
  - `snap` with `ce`=0 in IDLE: no frame, no count.
- Back-to-back and wrap: assert `snap` on every CSUM beat for 257 frames.
  - No idle cycles between frames.
  - Header seq runs 0..255 then 0.
- Reset mid-frame: assert `rst_N`=0 during weight 3.
  - `m_valid`/`busy`/`seq`/`drop_cnt` go to 0 asynchronously.
  - Next snap yields a clean frame with seq 0.
